// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
package fb_arb_pkg;
    localparam int FRAME_W      = 640;
    localparam int FRAME_H      = 480;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int FB_ADDR_W    = $clog2(FRAME_PIXELS);
    localparam int FB_DATA_W    = 3;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_RD,
        GNT_WR
    } gnt_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } wfifo_entry_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Write buffer: synchronous FIFO, registered count, valid/ready push, external pop.
module fb_wr_fifo #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 3,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [ADDR_WIDTH-1:0]     push_addr,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      pop,
    output logic [ADDR_WIDTH-1:0]     head_addr,
    output logic [DATA_WIDTH-1:0]     head_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]                    wptr;
    logic [PW-1:0]                    rptr;
    logic                             push;

    // Ready comes from the registered count only, so a full FIFO reopens a cycle after its pop.
    assign push_ready = (count != (PW+1)'(DEPTH));
    assign push       = push_valid & push_ready;
    assign empty      = (count == '0);
    assign {head_addr, head_data} = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && rst_n) mem[wptr] <= {push_addr, push_data};
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads have priority, buffered UART writes
// are forced in after a bounded run of reads.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = FB_ADDR_W,
    parameter int DATA_WIDTH  = FB_DATA_W,
    parameter int RAM_LATENCY = 2,
    parameter int WFIFO_DEPTH = 4,
    parameter int MAX_RD_RUN  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_req,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          rd_ack,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    output logic                          ram_we,
    input  logic [DATA_WIDTH-1:0]         ram_q,
    output logic [$clog2(WFIFO_DEPTH):0]  wfifo_count,
    output logic                          wr_forced
);
    localparam int RW = $clog2(MAX_RD_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_RD_RUN);

    gnt_e                   gnt;
    gnt_e                   gnt_q;
    logic [RW-1:0]          run_cnt;
    logic                   fifo_empty;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [RAM_LATENCY:0]   vld_pipe;

    fb_wr_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WFIFO_DEPTH)
    ) u_wfifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (wr_valid),
        .push_ready (wr_ready),
        .push_addr  (wr_addr),
        .push_data  (wr_data),
        .pop        (gnt == GNT_WR),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (wfifo_count),
        .empty      (fifo_empty)
    );

    // Held in reset, nothing is granted so queued writes cannot leak out.
    always_comb begin
        gnt = GNT_IDLE;
        if (!rst_n)
            gnt = GNT_IDLE;
        else if (!fifo_empty && (!rd_req || run_cnt == RUN_MAX))
            gnt = GNT_WR;
        else if (rd_req)
            gnt = GNT_RD;
    end

    assign rd_ack    = (gnt == GNT_RD);
    assign wr_forced = (gnt == GNT_WR) && rd_req;
    assign ram_we    = rst_n && (gnt_q == GNT_WR);
    assign rd_valid  = rst_n && vld_pipe[RAM_LATENCY];
    assign rd_data   = rd_valid ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q     <= GNT_IDLE;
            run_cnt   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            vld_pipe  <= '0;
        end else begin
            gnt_q    <= gnt;
            vld_pipe <= (RAM_LATENCY+1)'({vld_pipe, rd_ack});
            if (fifo_empty || gnt == GNT_WR)
                run_cnt <= '0;
            else if (gnt == GNT_RD && run_cnt != RUN_MAX)
                run_cnt <= run_cnt + 1'b1;
            case (gnt)
                GNT_RD: ram_addr <= rd_addr;
                GNT_WR: begin
                    ram_addr  <= head_addr;
                    ram_wdata <= head_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: RAM model, queue-based reference model, directed scenarios.
module tb_fb_port_arbiter;
    import fb_arb_pkg::*;

    localparam int AW = 19, DW = 3, LAT = 2, DEPTH = 4, MAXRUN = 8;

    logic          clk = 0, rst_n = 0, rd_req = 0, wr_valid = 0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ack, rd_valid, wr_ready, ram_we, wr_forced;
    logic [DW-1:0] rd_data, ram_wdata, ram_q;
    logic [AW-1:0] ram_addr;
    logic [2:0]    wfifo_count;

    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT),
                      .WFIFO_DEPTH(DEPTH), .MAX_RD_RUN(MAXRUN)) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_q(ram_q), .wfifo_count(wfifo_count), .wr_forced(wr_forced)
    );

    // RAM macro model: registered address, two-cycle q, read-before-write.
    logic [DW-1:0] ram [int];
    logic [DW-1:0] q1 = '0, q2 = '0;
    assign ram_q = q2;

    function automatic logic [DW-1:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : '0;
    endfunction

    always @(posedge clk) begin
        q1 <= ram_rd(int'(ram_addr));
        q2 <= q1;
        if (ram_we) ram[int'(ram_addr)] = ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: write queue, golden memory, expected read returns.
    typedef struct {int due; logic [DW-1:0] data;} rret_t;
    wfifo_entry_t  mq[$];
    rret_t         rq[$];
    logic [DW-1:0] gmem [int];
    int            mrun = 0;
    logic          m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    function automatic logic [DW-1:0] gm_rd(input int a);
        return gmem.exists(a) ? gmem[a] : '0;
    endfunction

    initial begin : scoreboard
        int g;
        bit has_q, push_ok, exp_v;
        wfifo_entry_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            has_q = (mq.size() != 0);
            g = 0;
            if (rst_n) begin
                if (has_q && (!rd_req || mrun == MAXRUN)) g = 2;
                else if (rd_req) g = 1;
            end
            chk("sb_rd_ack", rd_ack, g == 1);
            chk("sb_wr_forced", wr_forced, g == 2 && rd_req);
            chk("sb_wr_ready", wr_ready, mq.size() != DEPTH);
            chk("sb_wfifo_count", wfifo_count, mq.size());
            chk("sb_ram_we", ram_we, rst_n && m_we);
            chk("sb_ram_addr", ram_addr, m_addr);
            chk("sb_ram_wdata", ram_wdata, m_wdata);
            exp_v = rst_n && rq.size() > 0 && rq[0].due == cyc;
            chk("sb_rd_valid", rd_valid, exp_v);
            if (exp_v) begin
                chk("sb_rd_data", rd_data, rq[0].data);
                void'(rq.pop_front());
            end
            if (!rst_n) begin
                mq.delete(); rq.delete();
                mrun = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            end else begin
                push_ok = wr_valid && mq.size() != DEPTH;
                m_we = 0;
                if (g == 2) begin
                    e = mq.pop_front();
                    gmem[int'(e.addr)] = e.data;
                    m_we = 1; m_addr = e.addr; m_wdata = e.data; mrun = 0;
                end else if (g == 1) begin
                    rq.push_back('{due: cyc + 1 + LAT, data: gm_rd(int'(rd_addr))});
                    m_addr = rd_addr;
                    if (has_q && mrun < MAXRUN) mrun++;
                end
                if (!has_q) mrun = 0;
                if (push_ok) mq.push_back('{addr: wr_addr, data: wr_data});
            end
        end
    end

    // Spacing between landed writes while reads are held continuously.
    bit gap_en = 0;
    int last_we = -1;
    always @(negedge clk) begin
        if (!gap_en) last_we = -1;
        else if (ram_we) begin
            if (last_we >= 0) begin
                checks++;
                if (cyc - last_we > 9) begin
                    errors++;
                    $display("FAIL t4_write_gap: got %0d cycles, required <= 9", cyc - last_we);
                end
            end
            last_we = cyc;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rd_req = 0; wr_valid = 0;
        repeat (n) tick();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin : stim
        int n, acc_stall, i;
        bit found;
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;

        // T1: idle after reset
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_ram_we", ram_we, 0);
            chk("t1_wr_ready", wr_ready, 1);
            chk("t1_count", wfifo_count, 0);
            chk("t1_ram_addr", ram_addr, 0);
            chk("t1_rd_valid", rd_valid, 0);
            tick();
        end

        // T2: single write, then read-back
        wr_valid = 1; wr_addr = 19'h00100; wr_data = 3'b101;
        @(negedge clk); chk("t2_accept", wr_ready, 1);
        tick(); wr_valid = 0;
        @(negedge clk); chk("t2_we_early", ram_we, 0);
        tick();
        @(negedge clk);
        chk("t2_we", ram_we, 1); chk("t2_addr", ram_addr, 32'h100); chk("t2_wdata", ram_wdata, 5);
        tick(); tick(); tick();
        rd_req = 1; rd_addr = 19'h00100;
        @(negedge clk); chk("t2_rd_ack", rd_ack, 1);
        tick(); rd_req = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t2_rd_valid", rd_valid, k == 3);
            if (k == 3) chk("t2_rd_data", rd_data, 3'b101);
            tick();
        end

        // T3: continuous reads with one queued write
        idle(3);
        rd_req = 1; rd_addr = 19'h00200;
        wr_valid = 1; wr_addr = 19'h00300; wr_data = 3'b011;
        @(negedge clk); chk("t3_accept", wr_ready, 1);
        tick(); wr_valid = 0;
        n = 0; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (wr_forced) begin
                found = 1;
                chk("t3_forced_ack", rd_ack, 0);
            end else if (rd_ack) n++;
            tick();
        end
        chk("t3_forced_seen", found, 1);
        chk("t3_reads_before_force", n, 8);
        @(negedge clk);
        chk("t3_ram_we", ram_we, 1); chk("t3_ram_addr", ram_addr, 32'h300);
        chk("t3_ram_wdata", ram_wdata, 3); chk("t3_resume", rd_ack, 1);
        tick();

        // T4: six writes against continuous reads
        idle(3);
        rd_req = 1; rd_addr = 19'h00400; gap_en = 1;
        i = 0; acc_stall = -1;
        for (int c = 0; c < 200 && i < 6; c++) begin
            wr_valid = 1; wr_addr = 19'h01000 + 19'(i); wr_data = 3'(i + 1);
            @(negedge clk);
            if (wr_ready) i++;
            else if (acc_stall < 0) acc_stall = i;
            tick();
        end
        wr_valid = 0;
        chk("t4_accepts_before_stall", acc_stall, 4);
        chk("t4_all_accepted", i, 6);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wfifo_count == 0) break;
            tick();
        end
        tick(); tick();
        rd_req = 0; gap_en = 0;
        chk("t4_drained", wfifo_count, 0);
        for (int j = 0; j < 6; j++) chk("t4_ram", ram_rd(32'h1000 + j), j + 1);

        // T5: push and pop in the same cycle at count 2
        idle(3);
        rd_req = 1; rd_addr = 19'h00500;
        wr_valid = 1; wr_addr = 19'h02000; wr_data = 3'd1;
        tick();
        wr_addr = 19'h02001; wr_data = 3'd2;
        tick();
        rd_req = 0; wr_addr = 19'h02002; wr_data = 3'd4;
        @(negedge clk);
        chk("t5_count_before", wfifo_count, 2); chk("t5_ready", wr_ready, 1);
        tick(); wr_valid = 0;
        @(negedge clk); chk("t5_count_after", wfifo_count, 2);
        tick();
        idle(6);
        chk("t5_ram0", ram_rd(32'h2000), 1);
        chk("t5_ram1", ram_rd(32'h2001), 2);
        chk("t5_ram2", ram_rd(32'h2002), 4);

        // T6: reset with reads in flight and writes queued
        idle(3);
        wr_valid = 1; wr_addr = 19'h03000; wr_data = 3'd7;
        tick();
        wr_addr = 19'h03001; rd_req = 1; rd_addr = 19'h00100;
        @(negedge clk); chk("t6_rd_ack1", rd_ack, 1);
        tick();
        wr_addr = 19'h03002; rd_addr = 19'h00200;
        @(negedge clk); chk("t6_rd_ack2", rd_ack, 1);
        tick();
        wr_valid = 0; rd_req = 0;
        for (int k = 0; k < 10; k++) begin
            rst_n = (k >= 2);
            @(negedge clk);
            chk("t6_no_rd_valid", rd_valid, 0);
            chk("t6_no_we", ram_we, 0);
            if (k >= 1) chk("t6_count_zero", wfifo_count, 0);
            tick();
        end
        for (int j = 0; j < 3; j++) chk("t6_write_dropped", ram.exists(32'h3000 + j), 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
